// File: rtl/instr_fetch_seq.sv
// Instruction BRAM port arbiter and fetch sequencer: host loads while idle, then runs fetch/issue to STOP.
// Optional macro INSTR_PREFETCH_EN: on an ISSUE handshake, read pc+1 directly and skip the FETCH state.
module instr_fetch_seq #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned INSTR_WIDTH = 12,
    parameter logic [INSTR_WIDTH-1:0] START_WORD = 12'h000,
    parameter logic [INSTR_WIDTH-1:0] STOP_WORD  = 12'h008
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic                     host_we,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0]    host_wdata,
    output logic                     host_ready,
    output logic [$clog2(DEPTH)-1:0] bram_addr,
    output logic                     bram_we,
    output logic                     bram_re,
    output logic [DATA_WIDTH-1:0]    bram_wdata,
    input  logic [DATA_WIDTH-1:0]    bram_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_WIDTH-1:0]   instr_data,
    output logic [$clog2(DEPTH)-1:0] instr_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          pc_q, pc_d;
    logic [AW-1:0]          instr_pc_q, instr_pc_d;
    logic [INSTR_WIDTH-1:0] instr_data_q, instr_data_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   host_ready_q, host_ready_d;
    logic [INSTR_WIDTH-1:0] word;
    logic                   handshake;
    logic                   rdata_unused;

    // Only the low instruction field of the BRAM word is meaningful here.
    assign rdata_unused = ^bram_rdata[DATA_WIDTH-1:INSTR_WIDTH];
    assign word         = bram_rdata[INSTR_WIDTH-1:0];
    assign handshake    = instr_valid_q & instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            instr_pc_q    <= '0;
            instr_data_q  <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            host_ready_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            instr_data_q  <= instr_data_d;
            instr_valid_q <= instr_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            host_ready_q  <= host_ready_d;
        end
    end

    // Next-state logic plus the combinational BRAM port mux.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_pc_d    = instr_pc_q;
        instr_data_d  = instr_data_q;
        instr_valid_d = instr_valid_q;
        err_d         = err_q;
        done_d        = 1'b0;
        bram_we       = 1'b0;
        bram_re       = 1'b0;
        bram_addr     = pc_q;
        bram_wdata    = '0;

        case (state_q)
            S_IDLE, S_HALT: begin
                bram_we    = host_we;
                bram_addr  = host_addr;
                bram_wdata = host_wdata;
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                bram_re = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (word == STOP_WORD) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end else if (word == START_WORD) begin
                    if (pc_q == LAST_PC) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    instr_data_d  = word;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (handshake) begin
                    instr_valid_d = 1'b0;
                    if (pc_q == LAST_PC) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        pc_d = pc_q + AW'(1);
`ifdef INSTR_PREFETCH_EN
                        bram_re   = 1'b1;
                        bram_addr = pc_d;
                        state_d   = S_WAIT;
`else
                        state_d   = S_FETCH;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d       = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_ISSUE);
        host_ready_d = !busy_d;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign host_ready  = host_ready_q;
    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: BRAM model, program-level reference model, directed and random runs.
module tb_instr_fetch_seq;

    localparam int unsigned DW    = 128;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned IW    = 12;
    localparam int unsigned AW    = 8;
`ifdef INSTR_PREFETCH_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ready;
    logic [AW-1:0] bram_addr;
    logic          bram_we, bram_re;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata;
    logic          instr_valid;
    logic          instr_ready = 1'b1;
    logic [IW-1:0] instr_data;
    logic [AW-1:0] instr_pc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_c = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] gm  [DEPTH];
    logic [IW-1:0] exp_d[$];
    int            exp_p[$];
    logic          exp_err;

    instr_fetch_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
        .bram_addr(bram_addr), .bram_we(bram_we), .bram_re(bram_re), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    // Single-port BRAM with registered read.
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_wdata;
        if (bram_re) bram_rdata <= mem[bram_addr];
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Program semantics: walk from 0, skip START words, stop at STOP, overrun past the last entry.
    function automatic void build_expected();
        exp_d.delete();
        exp_p.delete();
        exp_err = 1'b0;
        for (int p = 0; p < DEPTH; p++) begin
            if (gm[p] == 12'h008) return;
            if (gm[p] != 12'h000) begin
                exp_d.push_back(gm[p]);
                exp_p.push_back(p);
            end
        end
        exp_err = 1'b1;
    endfunction

    task automatic host_write(input logic [AW-1:0] a, input logic [IW-1:0] w);
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = {$urandom, $urandom, $urandom, 20'($urandom), w};
        gm[a]      = w;
        #1;
        check("host_bram_we", 32'(bram_we), 32'd1);
        check("host_bram_addr", 32'(bram_addr), 32'(a));
        step();
        host_we = 1'b0;
    endtask

    task automatic start_run(input bit wr, input logic [AW-1:0] a, input logic [IW-1:0] w);
        start = 1'b1;
        if (wr) begin
            host_we    = 1'b1;
            host_addr  = a;
            host_wdata = {$urandom, $urandom, $urandom, 20'($urandom), w};
            gm[a]      = w;
        end
        #1;
        if (wr) check("start_wr_we", 32'(bram_we), 32'd1);
        start_c = cyc;
        step();
        start   = 1'b0;
        host_we = 1'b0;
    endtask

    // mode 0: ready high; 1: random ready and stray starts; 2: stall pc2 with host poke; 3: reset at pc2.
    task automatic run_check(input int mode);
        int  last_hs, stall, prev_pc;
        bit  prev_valid, seen_done, first;
        build_expected();
        last_hs = -1; stall = 0; prev_pc = -10;
        prev_valid = 1'b0; seen_done = 1'b0; first = 1'b1;
        for (int k = 0; k < 2000 && !seen_done; k++) begin
            instr_ready = 1'b1;
            host_we     = 1'b0;
            start       = 1'b0;
            if (mode == 1) begin
                instr_ready = 1'($urandom_range(0, 1));
                start       = busy && ($urandom_range(0, 9) == 0);
            end
            if (mode == 2 && instr_valid && instr_pc == 2 && stall < 5) begin
                instr_ready = 1'b0;
                stall++;
                host_we    = 1'b1;
                host_addr  = 8'd3;
                host_wdata = 128'h5;
            end
            if (mode == 3 && instr_valid && instr_pc == 2) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 0);
                check("rst_done", 32'(done), 0);
                check("rst_err", 32'(err), 0);
                check("rst_valid", 32'(instr_valid), 0);
                check("rst_data", 32'(instr_data), 0);
                check("rst_pc", 32'(instr_pc), 0);
                check("rst_bram_re", 32'(bram_re), 0);
                check("rst_bram_we", 32'(bram_we), 0);
                check("rst_host_ready", 32'(host_ready), 1);
                step();
                rst_n = 1'b1;
                step();
                return;
            end
            #1;
            if (k == 0) begin
                check("run_busy_first", 32'(busy), 1);
                check("run_err_cleared", 32'(err), 0);
                check("run_host_ready", 32'(host_ready), 0);
            end
            if (instr_valid && !prev_valid) begin
                if (first && exp_p.size() > 0 && exp_p[0] == 0)
                    check("start_latency", 32'(cyc - start_c), 32'd3);
                else if (!first && last_hs >= 0 && exp_p.size() > 0 && exp_p[0] == prev_pc + 1)
                    check("issue_gap", 32'(cyc - last_hs), 32'(GAP));
                first = 1'b0;
            end
            if (instr_valid) begin
                if (exp_d.size() == 0) check("unexpected_issue", 32'd1, 32'd0);
                else begin
                    check("instr_data", 32'(instr_data), 32'(exp_d[0]));
                    check("instr_pc", 32'(instr_pc), 32'(exp_p[0]));
                end
                if (!instr_ready) check("no_re_stall", 32'(bram_re), 0);
                else begin
                    if (exp_d.size() > 0) begin
                        void'(exp_d.pop_front());
                        void'(exp_p.pop_front());
                    end
                    last_hs = cyc;
                    prev_pc = int'(instr_pc);
                end
            end
            if (host_we) begin
                check("host_ready_run", 32'(host_ready), 0);
                check("bram_we_run", 32'(bram_we), 0);
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_busy", 32'(busy), 0);
                check("done_err", 32'(err), 32'(exp_err));
                check("done_left", 32'(exp_d.size()), 0);
                check("done_host_ready", 32'(host_ready), 1);
            end else begin
                check("busy_run", 32'(busy), 1);
            end
            prev_valid = instr_valid;
            step();
        end
        start = 1'b0; host_we = 1'b0; instr_ready = 1'b1;
        if (!seen_done) check("done_timeout", 32'd0, 32'd1);
        else begin
            check("done_pulse", 32'(done), 0);
            check("err_sticky", 32'(err), 32'(exp_err));
        end
    endtask

    task automatic load_test1();
        host_write(8'd0, 12'h000);
        host_write(8'd1, 12'h009);
        host_write(8'd2, 12'h00A);
        host_write(8'd3, 12'h003);
    endtask

    initial begin
        logic [IW-1:0] w;
        int            stop_pos;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            gm[i]  = '0;
        end
        step();
        step();
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_err", 32'(err), 0);
        check("reset_valid", 32'(instr_valid), 0);
        check("reset_data", 32'(instr_data), 0);
        check("reset_pc", 32'(instr_pc), 0);
        check("reset_bram_re", 32'(bram_re), 0);
        check("reset_bram_we", 32'(bram_we), 0);
        check("reset_host_ready", 32'(host_ready), 1);
        rst_n = 1'b1;
        step();

        // Load, with the STOP word written in the same cycle as start.
        load_test1();
        start_run(1'b1, 8'd4, 12'h008);
        run_check(0);

        // Backpressure on pc2 with a blocked host write.
        start_run(1'b0, '0, '0);
        run_check(2);
        check("mem3_untouched", 32'(mem[3][IW-1:0]), 32'h003);

        // Reset mid-run, then a clean rerun from pc0.
        start_run(1'b0, '0, '0);
        run_check(3);
        start_run(1'b0, '0, '0);
        run_check(0);

        // Overrun: no STOP anywhere.
        for (int i = 0; i < DEPTH; i++) host_write(8'(i), 12'h001);
        start_run(1'b0, '0, '0);
        run_check(0);
        load_test1();
        host_write(8'd4, 12'h008);
        start_run(1'b0, '0, '0);
        run_check(1);

        // Random programs with random backpressure.
        for (int r = 0; r < 4; r++) begin
            stop_pos = $urandom_range(1, 60);
            for (int i = 0; i < DEPTH; i++) begin
                w = 12'($urandom);
                if (w == 12'h000 || w == 12'h008) w = 12'h123;
                if (i < stop_pos && $urandom_range(0, 3) == 0) w = 12'h000;
                if (i == stop_pos) w = 12'h008;
                host_write(8'(i), w);
            end
            start_run(1'b0, '0, '0);
            run_check(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
